// File: rtl/arbitro_mux_3in.sv
// rtl/arbitro_mux_3in.sv - three-requester round-robin bus arbiter with burst limit and registered mux select
module arbitro_mux_3in #(
  parameter int MAX_RAFAGA = 4,
  parameter int ANCHO_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           Req,
  output logic [2:0]           Grant,
  output logic [1:0]           Sel,
  output logic                 Valido,
  output logic [ANCHO_CNT-1:0] Cuenta
);

  localparam logic [0:0] LIBRE    = 1'b0;
  localparam logic [0:0] OTORGADO = 1'b1;

  localparam logic [ANCHO_CNT-1:0] MAX_CNT = ANCHO_CNT'(MAX_RAFAGA);
  localparam logic [ANCHO_CNT-1:0] UNO     = ANCHO_CNT'(1);

  logic [0:0]           state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [1:0]           sel_q, sel_d;
  logic                 valido_q, valido_d;
  logic [ANCHO_CNT-1:0] cuenta_q, cuenta_d;
  logic [1:0]           ultimo_q, ultimo_d;

  logic [1:0] ord [3];
  logic [1:0] win;
  logic       win_ok;
  logic       owner_req;
  logic       rafaga_fin;

  // Priority list starts after the last owner; the last owner itself comes last,
  // so a lone requester is re-granted when its burst expires.
  always_comb begin
    ord[0] = 2'd0;
    ord[1] = 2'd1;
    ord[2] = 2'd2;
    case (ultimo_q)
      2'd0: begin ord[0] = 2'd1; ord[1] = 2'd2; ord[2] = 2'd0; end
      2'd1: begin ord[0] = 2'd2; ord[1] = 2'd0; ord[2] = 2'd1; end
      default: begin ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; end
    endcase
    win    = ultimo_q;
    win_ok = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (Req[ord[k]]) begin
        win    = ord[k];
        win_ok = 1'b1;
      end
    end
  end

  assign owner_req  = Req[ultimo_q];
  assign rafaga_fin = (cuenta_q >= MAX_CNT);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    cuenta_d = cuenta_q;
    ultimo_d = ultimo_q;
    if (state_q == OTORGADO && owner_req && !rafaga_fin) begin
      cuenta_d = cuenta_q + UNO;
    end else if (win_ok) begin
      state_d  = OTORGADO;
      grant_d  = 3'b001 << win;
      sel_d    = win;
      ultimo_d = win;
      cuenta_d = UNO;
    end else begin
      state_d  = LIBRE;
      grant_d  = 3'b000;
      cuenta_d = '0;
    end
    valido_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LIBRE;
      grant_q  <= 3'b000;
      sel_q    <= 2'b00;
      valido_q <= 1'b0;
      cuenta_q <= '0;
      ultimo_q <= 2'd2;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      valido_q <= valido_d;
      cuenta_q <= cuenta_d;
      ultimo_q <= ultimo_d;
    end
  end

  assign Grant  = grant_q;
  assign Sel    = sel_q;
  assign Valido = valido_q;
  assign Cuenta = cuenta_q;

endmodule

// File: tb/tb_arbitro_mux_3in.sv
// tb/tb_arbitro_mux_3in.sv - self-checking bench for arbitro_mux_3in
module tb_arbitro_mux_3in;

  localparam int MAXR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] Req;
  logic [2:0] Grant;
  logic [1:0] Sel;
  logic       Valido;
  logic [3:0] Cuenta;

  int n_chk = 0;
  int n_err = 0;

  // reference model: owner index (-1 = none), burst count, last owner, held select
  int m_owner;
  int m_cnt;
  int m_last;
  int m_sel;

  arbitro_mux_3in #(.MAX_RAFAGA(MAXR), .ANCHO_CNT(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .Req    (Req),
    .Grant  (Grant),
    .Sel    (Sel),
    .Valido (Valido),
    .Cuenta (Cuenta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [2:0] r);
    int w;
    int c;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = 2; m_sel = 0;
    end else if (m_owner < 0 || !r[m_owner] || m_cnt == MAXR) begin
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (w < 0 && r[c]) w = c;
      end
      if (w >= 0) begin
        m_owner = w; m_last = w; m_sel = w; m_cnt = 1;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] r);
    logic [7:0] eg;
    @(negedge clk);
    reset = rst;
    Req   = r;
    @(posedge clk);
    model_edge(rst, r);
    #1;
    eg = (m_owner < 0) ? 8'd0 : 8'(1 << m_owner);
    chk("grant", 8'(Grant), eg);
    chk("sel", 8'(Sel), 8'(m_sel));
    chk("valido", 8'(Valido), 8'(m_owner >= 0));
    chk("cuenta", 8'(Cuenta), 8'(m_cnt));
    chk("onehot0", 8'($onehot0(Grant)), 8'd1);
    chk("sel_not_3", 8'(Sel != 2'b11), 8'd1);
    chk("cuenta_le_max", 8'(int'(Cuenta) <= MAXR), 8'd1);
  endtask

  initial begin
    logic [2:0] r;
    reset = 1'b1;
    Req   = 3'b000;
    m_owner = -1; m_cnt = 0; m_last = 2; m_sel = 0;

    step(1'b1, 3'b000);
    step(1'b1, 3'b111);
    chk("rst_grant", 8'(Grant), 8'd0);
    chk("rst_cuenta", 8'(Cuenta), 8'd0);

    // all three requesting: 4-cycle bursts A, B, C, then A again
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 3'b111);
      chk("rr_grant", 8'(Grant), (i < 4) ? 8'd1 : (i < 8) ? 8'd2 : (i < 12) ? 8'd4 : 8'd1);
      chk("rr_sel", 8'(Sel), (i < 4) ? 8'd0 : (i < 8) ? 8'd1 : (i < 12) ? 8'd2 : 8'd0);
    end

    // B requests for two cycles then drops; select stays at B
    step(1'b1, 3'b000);
    step(1'b0, 3'b010);
    chk("b_grant1", 8'(Grant), 8'd2);
    step(1'b0, 3'b010);
    chk("b_grant2", 8'(Grant), 8'd2);
    step(1'b0, 3'b000);
    chk("b_free_grant", 8'(Grant), 8'd0);
    chk("b_free_sel", 8'(Sel), 8'd1);
    step(1'b0, 3'b000);
    chk("b_hold_sel", 8'(Sel), 8'd1);

    // lone requester C is re-granted every burst
    step(1'b1, 3'b000);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 3'b100);
      chk("c_grant", 8'(Grant), 8'd4);
      chk("c_cuenta", 8'(Cuenta), 8'((i % 4) + 1));
    end

    // A owns, C joins, A drops at Cuenta = 2
    step(1'b1, 3'b000);
    step(1'b0, 3'b001);
    step(1'b0, 3'b101);
    chk("a_cuenta2", 8'(Cuenta), 8'd2);
    step(1'b0, 3'b100);
    chk("handoff_grant", 8'(Grant), 8'd4);
    chk("handoff_cuenta", 8'(Cuenta), 8'd1);

    // reset mid-ownership of B
    step(1'b1, 3'b000);
    step(1'b0, 3'b010);
    step(1'b0, 3'b010);
    step(1'b0, 3'b010);
    chk("pre_rst_cuenta", 8'(Cuenta), 8'd3);
    step(1'b1, 3'b111);
    chk("mid_rst_grant", 8'(Grant), 8'd0);
    chk("mid_rst_sel", 8'(Sel), 8'd0);
    chk("mid_rst_valido", 8'(Valido), 8'd0);
    chk("mid_rst_cuenta", 8'(Cuenta), 8'd0);
    step(1'b0, 3'b111);
    chk("post_rst_grant", 8'(Grant), 8'd1);

    // randomized traffic with occasional resets and held requests
    r = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) r = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 59) == 0), r);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
